// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared command codes, fixed operand addresses and the controller state encoding
// for the SYS_TOP command controller.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OPA,
    ST_OPB,
    ST_FUN,
    ST_ALU_START,
    ST_ALU_WAIT,
    ST_SEND_HI,
    ST_SEND_LO
  } ctrl_state_e;

  // States that wait on the UART and are therefore covered by the frame watchdog.
  function automatic logic is_timed_state(input ctrl_state_e s);
    return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OPA, ST_OPB, ST_FUN};
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Bundle of the controller's RX, register-file, ALU and TX FIFO signals.
// master = controller side, slave = surrounding system side.
interface sys_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic                    WrEn;
  logic                    RdEn;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WrData;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_Valid;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    FIFO_FULL;
  logic                    CTRL_BUSY;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD,
           CTRL_BUSY
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD,
           CTRL_BUSY
  );
endinterface

// File: rtl/sys_cmd_ctrl_tx_sender.sv
// Response sequencer into the TX FIFO: optional high byte, then low byte, each pushed
// only when FIFO_FULL is low; o_done pulses together with the final byte's strobe.
module ctrl_tx_sender #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_hi_en,
  input  logic [DATA_WIDTH-1:0] i_hi_byte,
  input  logic [DATA_WIDTH-1:0] i_lo_byte,
  input  logic                  i_fifo_full,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_vld,
  output logic                  o_done
);
  logic                  r_active;
  logic                  r_hi_pend;
  logic                  r_tx_vld;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] r_lo_byte;

  // A push is never issued in the cycle right after another one, so FIFO_FULL has
  // had a cycle to reflect the previous write before it is trusted again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_hi_pend <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_done    <= 1'b0;
      r_tx_data <= '0;
      r_lo_byte <= '0;
    end else begin
      r_tx_vld <= 1'b0;
      r_done   <= 1'b0;
      if (i_start) begin
        r_active  <= 1'b1;
        r_hi_pend <= i_hi_en;
        r_lo_byte <= i_lo_byte;
        r_tx_data <= i_hi_en ? i_hi_byte : i_lo_byte;
      end else if (r_active && !r_tx_vld && !i_fifo_full) begin
        r_tx_vld <= 1'b1;
        if (r_hi_pend) begin
          r_hi_pend <= 1'b0;
        end else begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end else if (r_active && r_tx_vld) begin
        r_tx_data <= r_lo_byte;
      end
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_vld  = r_tx_vld;
  assign o_done    = r_done;
endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command controller: parses RX byte frames, strobes the RF/ALU and returns responses
// to the TX FIFO. Define CMD_TIMEOUT_EN to compile in the inter-frame watchdog.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input logic            REF_CLK,
  input logic            RST,
  sys_cmd_ctrl_if.master bus
);
  ctrl_state_e           r_state, w_state_next;
  logic                  r_wr_en, w_wr_en_next;
  logic                  r_rd_en, w_rd_en_next;
  logic                  r_alu_en, w_alu_en_next;
  logic                  r_clk_en, w_clk_en_next;
  logic                  r_busy, w_busy_next;
  logic [ADDR_WIDTH-1:0] r_address, w_address_next;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_next;
  logic [FUN_WIDTH-1:0]  r_alu_fun, w_alu_fun_next;
  logic                  w_send_start, w_send_hi_en;
  logic [DATA_WIDTH-1:0] w_send_hi, w_send_lo;
  logic [DATA_WIDTH-1:0] w_tx_data;
  logic                  w_tx_vld, w_tx_done;
  logic                  w_timeout;

  assign w_send_hi = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_send_lo = (r_state == ST_RD_WAIT) ? bus.RdData : bus.ALU_OUT[DATA_WIDTH-1:0];

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST)
      r_to_cnt <= '0;
    else if (bus.RX_D_VLD || (w_state_next != r_state))
      r_to_cnt <= '0;
    else if (is_timed_state(r_state))
      r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = is_timed_state(r_state) && !bus.RX_D_VLD &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_wr_en_next   = 1'b0;
    w_rd_en_next   = 1'b0;
    w_alu_en_next  = 1'b0;
    w_address_next = r_address;
    w_wr_data_next = r_wr_data;
    w_alu_fun_next = r_alu_fun;
    w_send_start   = 1'b0;
    w_send_hi_en   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.RX_D_VLD) begin
        case (bus.RX_P_DATA)
          CMD_RF_WR:   w_state_next = ST_WR_ADDR;
          CMD_RF_RD:   w_state_next = ST_RD_ADDR;
          CMD_ALU_OP:  w_state_next = ST_OPA;
          CMD_ALU_NOP: w_state_next = ST_FUN;
          default:     w_state_next = ST_IDLE;
        endcase
      end
      ST_WR_ADDR: if (bus.RX_D_VLD) begin
        w_address_next = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        w_state_next   = ST_WR_DATA;
      end
      ST_WR_DATA: if (bus.RX_D_VLD) begin
        w_wr_data_next = bus.RX_P_DATA;
        w_wr_en_next   = 1'b1;
        w_state_next   = ST_IDLE;
      end
      ST_RD_ADDR: if (bus.RX_D_VLD) begin
        w_address_next = bus.RX_P_DATA[ADDR_WIDTH-1:0];
        w_rd_en_next   = 1'b1;
        w_state_next   = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (bus.RdData_Valid) begin
        w_send_start = 1'b1;
        w_state_next = ST_SEND_LO;
      end
      ST_OPA: if (bus.RX_D_VLD) begin
        w_address_next = ADDR_WIDTH'(OPA_ADDR);
        w_wr_data_next = bus.RX_P_DATA;
        w_wr_en_next   = 1'b1;
        w_state_next   = ST_OPB;
      end
      ST_OPB: if (bus.RX_D_VLD) begin
        w_address_next = ADDR_WIDTH'(OPB_ADDR);
        w_wr_data_next = bus.RX_P_DATA;
        w_wr_en_next   = 1'b1;
        w_state_next   = ST_FUN;
      end
      // ALU_EN is registered from this transition so it is high while in ALU_START.
      ST_FUN: if (bus.RX_D_VLD) begin
        w_alu_fun_next = bus.RX_P_DATA[FUN_WIDTH-1:0];
        w_alu_en_next  = 1'b1;
        w_state_next   = ST_ALU_START;
      end
      ST_ALU_START: w_state_next = ST_ALU_WAIT;
      ST_ALU_WAIT: if (bus.OUT_Valid) begin
        w_send_start = 1'b1;
        w_send_hi_en = 1'b1;
        w_state_next = ST_SEND_HI;
      end
      ST_SEND_HI: if (w_tx_vld)  w_state_next = ST_SEND_LO;
      ST_SEND_LO: if (w_tx_done) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
    if (w_timeout)
      w_state_next = ST_IDLE;
    w_clk_en_next = w_state_next inside {ST_FUN, ST_ALU_START, ST_ALU_WAIT};
    w_busy_next   = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_alu_en  <= 1'b0;
      r_clk_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_address <= '0;
      r_wr_data <= '0;
      r_alu_fun <= '0;
    end else begin
      r_state   <= w_state_next;
      r_wr_en   <= w_wr_en_next;
      r_rd_en   <= w_rd_en_next;
      r_alu_en  <= w_alu_en_next;
      r_clk_en  <= w_clk_en_next;
      r_busy    <= w_busy_next;
      r_address <= w_address_next;
      r_wr_data <= w_wr_data_next;
      r_alu_fun <= w_alu_fun_next;
    end
  end

  ctrl_tx_sender #(.DATA_WIDTH(DATA_WIDTH)) u_tx_sender (
    .clk         (REF_CLK),
    .rst_n       (RST),
    .i_start     (w_send_start),
    .i_hi_en     (w_send_hi_en),
    .i_hi_byte   (w_send_hi),
    .i_lo_byte   (w_send_lo),
    .i_fifo_full (bus.FIFO_FULL),
    .o_tx_data   (w_tx_data),
    .o_tx_vld    (w_tx_vld),
    .o_done      (w_tx_done)
  );

  assign bus.WrEn      = r_wr_en;
  assign bus.RdEn      = r_rd_en;
  assign bus.Address   = r_address;
  assign bus.WrData    = r_wr_data;
  assign bus.ALU_EN    = r_alu_en;
  assign bus.ALU_FUN   = r_alu_fun;
  assign bus.CLK_EN    = r_clk_en;
  assign bus.CTRL_BUSY = r_busy;
  assign bus.TX_P_DATA = w_tx_data;
  assign bus.TX_D_VLD  = w_tx_vld;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl: expected RF/ALU/TX events are queued when frames
// are driven and checked by a negedge monitor. Honors CMD_TIMEOUT_EN.
module tb_sys_cmd_ctrl;
  localparam int TB_TO = 64;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  wr_t        wr_q[$];
  logic [3:0] rd_q[$];
  logic [3:0] alu_q[$];
  logic [7:0] tx_q[$];

  logic prev_wr, prev_rd, prev_alu, prev_tx;

  sys_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

  sys_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .REF_CLK (clk),
    .RST     (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: every DUT strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.WrEn) begin
        chk_val("wr_rd_excl", bus.RdEn, 0);
        chk_val("wr_one_cycle", prev_wr, 0);
        chk_val("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          wr_t e;
          e = wr_q.pop_front();
          chk_val("wr_addr", bus.Address, e.addr);
          chk_val("wr_data", bus.WrData, e.data);
          $display("WR   addr=%0h data=%02h", bus.Address, bus.WrData);
        end
      end
      if (bus.RdEn) begin
        chk_val("rd_one_cycle", prev_rd, 0);
        chk_val("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          logic [3:0] a;
          a = rd_q.pop_front();
          chk_val("rd_addr", bus.Address, a);
          $display("RD   addr=%0h", bus.Address);
        end
      end
      if (bus.ALU_EN) begin
        chk_val("alu_one_cycle", prev_alu, 0);
        chk_val("alu_clk_en", bus.CLK_EN, 1);
        chk_val("alu_expected", alu_q.size() != 0, 1);
        if (alu_q.size() != 0) begin
          logic [3:0] f;
          f = alu_q.pop_front();
          chk_val("alu_fun", bus.ALU_FUN, f);
          $display("ALU  fun=%0h", bus.ALU_FUN);
        end
      end
      if (bus.TX_D_VLD) begin
        chk_val("tx_one_cycle", prev_tx, 0);
        chk_val("tx_not_full", bus.FIFO_FULL, 0);
        chk_val("tx_expected", tx_q.size() != 0, 1);
        if (tx_q.size() != 0) begin
          logic [7:0] b;
          b = tx_q.pop_front();
          chk_val("tx_byte", bus.TX_P_DATA, b);
          $display("TX   byte=%02h", bus.TX_P_DATA);
        end
      end
    end
    prev_wr  <= bus.WrEn;
    prev_rd  <= bus.RdEn;
    prev_alu <= bus.ALU_EN;
    prev_tx  <= bus.TX_D_VLD;
  end

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge clk);
    #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic rf_respond(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!bus.RdEn && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_val("rden_seen", bus.RdEn, 1);
    @(posedge clk);
    #1;
    bus.RdData       = d;
    bus.RdData_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.RdData_Valid = 1'b0;
  endtask

  task automatic alu_respond(input logic [15:0] r);
    int n = 0;
    @(negedge clk);
    while (!bus.ALU_EN && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_val("aluen_seen", bus.ALU_EN, 1);
    repeat (2) @(posedge clk);
    #1;
    bus.ALU_OUT   = r;
    bus.OUT_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.OUT_Valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (bus.CTRL_BUSY && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_val("back_to_idle", bus.CTRL_BUSY, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.RX_P_DATA    = '0;
    bus.RX_D_VLD     = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    bus.ALU_OUT      = '0;
    bus.OUT_Valid    = 1'b0;
    bus.FIFO_FULL    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_val("rst_outs", {bus.WrEn, bus.RdEn, bus.ALU_EN, bus.CLK_EN, bus.TX_D_VLD,
                         bus.CTRL_BUSY}, 0);
    chk_val("rst_addr", bus.Address, 0);
    chk_val("rst_wrdata", bus.WrData, 0);
    chk_val("rst_txdata", bus.TX_P_DATA, 0);

    // RF write
    wr_q.push_back('{addr: 4'h5, data: 8'hA6});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'hA6);
    wait_idle(20);

    // RF read
    rd_q.push_back(4'h5);
    tx_q.push_back(8'hA6);
    send_byte(8'hBB); send_byte(8'h05);
    rf_respond(8'hA6);
    wait_idle(20);

    // ALU with operands: 40 - 30 = 10
    wr_q.push_back('{addr: 4'h0, data: 8'd40});
    wr_q.push_back('{addr: 4'h1, data: 8'd30});
    alu_q.push_back(4'h1);
    tx_q.push_back(8'h00); tx_q.push_back(8'h0A);
    send_byte(8'hCC); send_byte(8'd40); send_byte(8'd30); send_byte(8'h01);
    alu_respond(16'd10);
    wait_idle(30);
    chk_val("clk_en_after_alu", bus.CLK_EN, 0);

    // ALU without operands
    alu_q.push_back(4'h0);
    tx_q.push_back(8'h00); tx_q.push_back(8'h46);
    send_byte(8'hDD); send_byte(8'h00);
    alu_respond(16'd70);
    wait_idle(30);

    // Backpressure: FIFO full for 20 cycles while the high byte waits; stray byte dropped
    bus.FIFO_FULL = 1'b1;
    alu_q.push_back(4'h3);
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    send_byte(8'hDD); send_byte(8'h03);
    alu_respond(16'h1234);
    repeat (8) @(posedge clk);
    send_byte(8'hAA);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk_val("stall_busy", bus.CTRL_BUSY, 1);
    chk_val("stall_txdata", bus.TX_P_DATA, 8'h12);
    chk_val("stall_q_pending", tx_q.size(), 2);
    @(posedge clk);
    #1;
    bus.FIFO_FULL = 1'b0;
    wait_idle(30);

    // Unknown byte dropped, then a normal write
    send_byte(8'h3C);
    @(negedge clk);
    chk_val("unknown_dropped", bus.CTRL_BUSY, 0);
    wr_q.push_back('{addr: 4'h2, data: 8'h11});
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    wait_idle(20);

    // Asynchronous reset mid-command
    send_byte(8'hDD);
    @(negedge clk);
    chk_val("clk_en_in_fun", bus.CLK_EN, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rst_clk_en", bus.CLK_EN, 0);
    chk_val("async_rst_busy", bus.CTRL_BUSY, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef CMD_TIMEOUT_EN
    send_byte(8'hAA);
    repeat (TB_TO - 4) @(negedge clk);
    chk_val("to_still_busy", bus.CTRL_BUSY, 1);
    repeat (8) @(negedge clk);
    chk_val("to_expired", bus.CTRL_BUSY, 0);
    rd_q.push_back(4'h5);
    tx_q.push_back(8'h5A);
    send_byte(8'hBB); send_byte(8'h05);
    rf_respond(8'h5A);
    wait_idle(20);
`else
    wr_q.push_back('{addr: 4'h3, data: 8'h44});
    send_byte(8'hAA);
    repeat (100) @(negedge clk);
    chk_val("no_to_busy", bus.CTRL_BUSY, 1);
    send_byte(8'h03); send_byte(8'h44);
    wait_idle(20);
`endif

    repeat (4) @(negedge clk);
    chk_val("wr_q_drained", wr_q.size(), 0);
    chk_val("rd_q_drained", rd_q.size(), 0);
    chk_val("alu_q_drained", alu_q.size(), 0);
    chk_val("tx_q_drained", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0b, expected completion",
             bus.CTRL_BUSY);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Command controller in the REF_CLK domain of SYS_TOP.
- Parses byte frames delivered by the UART receiver (after synchronization) and sequences the register file and the ALU.
- Pushes response bytes into the TX async FIFO.
- Supported commands: RF write (0xAA), RF read (0xBB), ALU with operands (0xCC), ALU without operands (0xDD).

Parameters:
- DATA_WIDTH, 8, frame/RF data width.
- ADDR_WIDTH, 4, RF address width; frame address bits above ADDR_WIDTH are ignored.
- FUN_WIDTH, 4, ALU function code width; upper frame bits are ignored.
- TIMEOUT_CYCLES, 16384, inter-frame watchdog limit (used only with CMD_TIMEOUT_EN).

Ports:
- REF_CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse; byte is valid and error-free.
- WrEn  out  1  RF write strobe, one cycle.
- RdEn  out  1  RF read strobe, one cycle.
- Address  out  ADDR_WIDTH  RF address.
- WrData  out  DATA_WIDTH  RF write data.
- RdData  in  DATA_WIDTH  RF read data.
- RdData_Valid  in  1  RF read data valid pulse.
- ALU_EN  out  1  ALU start pulse.
- ALU_FUN  out  FUN_WIDTH  ALU function code.
- CLK_EN  out  1  ALU clock-gate enable.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- OUT_Valid  in  1  ALU result valid pulse.
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.
- FIFO_FULL  in  1  TX FIFO full.
- CTRL_BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs are registered and reset to 0; state is IDLE.
- Strobe timing: a strobe caused by a byte sampled at edge N is high during cycle N+1 only.

States and transitions:
- IDLE, on RX_D_VLD, dispatches on the byte:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> OPA.
  - 0xDD -> FUN.
  - Any other byte is dropped; stay in IDLE.
- WR_ADDR: on RX_D_VLD, latch the address -> WR_DATA.
- WR_DATA: on RX_D_VLD, pulse WrEn for one cycle with Address/WrData -> IDLE.
- RD_ADDR: on RX_D_VLD, pulse RdEn with Address -> RD_WAIT.
- RD_WAIT: on RdData_Valid, latch RdData -> SEND_LO.
- OPA: on RX_D_VLD, WrEn to address 0 with the byte -> OPB.
- OPB: on RX_D_VLD, WrEn to address 1 with the byte -> FUN.
- FUN:
  - CLK_EN rises on entry and stays high through FUN, ALU_START and ALU_WAIT.
  - On RX_D_VLD, latch ALU_FUN -> ALU_START.
- ALU_START: pulse ALU_EN for one cycle -> ALU_WAIT.
- ALU_WAIT: on OUT_Valid, latch ALU_OUT -> SEND_HI; CLK_EN drops on exit.
- SEND_HI: present ALU_OUT[15:8] on TX_P_DATA; pulse TX_D_VLD in the first cycle FIFO_FULL=0 -> SEND_LO.
- SEND_LO: send the latched low byte (read data or ALU_OUT[7:0]) under the same FIFO_FULL rule -> IDLE.

Ordering and edge cases:
- Byte order: ALU responses are high byte first; RF read sends one byte.
- Backpressure: TX_D_VLD is never asserted while FIFO_FULL=1. TX_P_DATA stays stable while stalled.
- RX_D_VLD in RD_WAIT, ALU_WAIT, ALU_START, SEND_*: the byte is dropped and no state change occurs.
- RdData_Valid or OUT_Valid outside its wait state is ignored.
- WrEn and RdEn are never asserted together.
- ALU_EN is never asserted while CLK_EN=0.
- Reset mid-command: asynchronous return to IDLE; all strobes and CLK_EN drop immediately. A partial command is lost.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN.
  - It clears on every RX_D_VLD and on state entry.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE with no RF/ALU strobe and CLK_EN drops.
  - Wait states (RD_WAIT, ALU_WAIT, SEND_*) are not timed.
- Undefined: no counter; a partial command waits indefinitely.

Decomposition:
- Package sys_ctrl_pkg holds:
  - Command constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - OPA_ADDR=0 and OPB_ADDR=1.
  - The state enum typedef.
- One sub-module, ctrl_tx_sender: a two-byte send sequencer with FIFO_FULL handshake. Ports: start, hi-byte enable, two bytes, done.

Test Plan:
- 0xAA,0x05,0xA6 -> single-cycle WrEn with Address=5, WrData=0xA6; no TX_D_VLD.
- 0xBB,0x05, RF returns 0xA6 -> RdEn with Address=5, then one TX_D_VLD with TX_P_DATA=0xA6.
- 0xCC,40,30,0x01 -> WrEn addr0=40 then addr1=30; ALU_EN with ALU_FUN=1. Result 10 -> TX bytes 0x00 then 0x0A; CLK_EN low afterward.
- 0xDD,0x00, result 70 -> no WrEn; TX bytes 0x00 then 0x46.
- FIFO_FULL held high 20 cycles during SEND_HI -> no TX_D_VLD while full. Both bytes are sent in order after release; stray RX_D_VLD during the stall is ignored.
- Unknown byte 0x3C then 0xAA,0x02,0x11 -> 0x3C is dropped; write to addr 2 executes.
- With CMD_TIMEOUT_EN: 0xAA then silence for TIMEOUT_CYCLES -> return to IDLE, no WrEn. A following 0xBB,0x05 works normally.
